uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 serial transmitter.
- Configurable data width, parity mode and stop-bit count.
- Clean valid/ready input handshake, with back-to-back frames and no idle gap.
- Exact per-bit timing.
- Sits between the TDC result formatter (byte/word source) and the board UART TX pin.

Parameters:
CLK_FREQ, 132000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide, must be >= 2)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
s_data  input  DATA_BITS  payload, sampled only on handshake
s_valid  input  1  source has a payload
s_ready  output  1  transmitter can accept a payload this cycle
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse after the final stop bit completes

Behaviour:
- Reset values: tx=1, busy=0, done=0, state=IDLE, bit timer=0, bit index=0. s_ready=1 in the first cycle after reset.
- Handshake: accept when s_valid && s_ready at a rising edge. s_data is latched into a shift register at that edge; later changes to s_data are ignored.
- s_ready is high in IDLE and in the last clock of the last stop bit; it is low otherwise.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE, or -> START directly on back-to-back acceptance.
- Each bit lasts exactly CLKS_PER_BIT cycles. The timer counts 0..CLKS_PER_BIT-1 and advances state/bit at terminal count.
- tx is 0 from the edge of acceptance for CLKS_PER_BIT cycles (start bit).
- DATA: LSB first, DATA_BITS bits; the bit index wraps to 0 on leaving DATA.
- PARITY: odd = ~^payload, even = ^payload, computed from the latched payload.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles from acceptance edge to next possible start edge.
- done: asserted for exactly one cycle, in the cycle following the terminal count of the last stop bit. This holds regardless of whether a new frame starts then.
- Back-to-back: if s_valid is high in the last stop-bit cycle, the next start bit begins on the following edge. There is no extra high cycle.
- s_valid while busy (outside the last stop cycle): no effect, no data loss in flight, payload waits.
- Reset mid-frame: the next cycle has tx=1, IDLE, busy=0, and no done pulse. The frame is silently aborted.
- Reset dominates a simultaneous handshake.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (NONE, ODD, EVEN)
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - function clks_per_bit(freq, baud)
- Elaboration-time assertions check the legal DATA_BITS, STOP_BITS and CLKS_PER_BIT ranges.
- One sub-module, uart_bit_timer:
  - Parametrised down-counter with load/enable.
  - Outputs a terminal-count pulse.
  - Will be reused by the planned receiver.

Test Plan:
Use CLK_FREQ=1000000 and BAUD_RATE=100000 (CLKS_PER_BIT=10) unless stated.
1. 8N1, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. done pulses once at cycle 100 after acceptance. s_ready is low over cycles 1..98.
2. DATA_BITS=7, PARITY=2, send 0x53 (four ones) -> parity bit 0, frame 100 cycles. Same payload with PARITY=1 -> parity bit 1.
3. STOP_BITS=2, 8N2, send 0x00 -> tx low 90 cycles then high 20 cycles. done pulses at cycle 110.
4. Back-to-back 0x0F then 0xF0 with s_valid held -> second start-bit falling edge exactly 100 cycles after the first. done pulses between frames, no extra high cycle.
5. Reset asserted during data bit 3 of 0xFF -> tx=1, busy=0, s_ready=1 the next cycle, no done pulse. A following 0x3C transmits bit-exact.
6. Change s_data to 0x55 and pulse s_valid mid-frame while sending 0xAA -> line carries 0xAA unaltered. 0x55 is accepted only in the last stop-bit cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the configurable UART blocks
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter producing a per-bit terminal-count pulse
module uart_bit_timer #(
    parameter int unsigned TOP = 9,
    parameter int          W   = (TOP < 1) ? 1 : $clog2(TOP + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count_q;

    // Load starts a fresh bit period; the count parks at zero once it expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= W'(TOP);
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc = en && (count_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable-frame UART transmitter with valid/ready input
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 132000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int      CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam parity_e PAR_MODE     = parity_e'(PARITY[1:0]);
    localparam bit      HAS_PARITY   = (PARITY != 0);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic    LAST_STOP    = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_chk_clks_per_bit
        $error("uart_tx_cfg: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 timer_tc;
    logic                 timer_load;
    logic                 last_stop;
    logic                 accept;
    logic                 new_parity;

    uart_bit_timer #(
        .TOP (CLKS_PER_BIT - 1)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .en    (state_q != S_IDLE),
        .tc    (timer_tc)
    );

    // The final clock of the final stop bit doubles as an accept slot for back-to-back frames.
    assign last_stop  = (state_q == S_STOP) && timer_tc && (stop_idx_q == LAST_STOP);
    assign s_ready    = (state_q == S_IDLE) || last_stop;
    assign accept     = s_valid && s_ready;
    assign timer_load = accept || (timer_tc && !last_stop);
    assign new_parity = (PAR_MODE == PAR_ODD) ? ~^s_data : ^s_data;

    // State register plus all frame-tracking registers; tx and done are registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; tx_d is the line level for the bit that the next cycle begins.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d   = S_START;
                    shreg_d   = s_data;
                    par_d     = new_parity;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (timer_tc) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (timer_tc) begin
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        if (HAS_PARITY) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (timer_tc) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                if (timer_tc) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done_d = 1'b1;
                        if (accept) begin
                            state_d   = S_START;
                            shreg_d   = s_data;
                            par_d     = new_parity;
                            bit_idx_d = '0;
                            tx_d      = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] sd  [4];
    logic       sv  [4];
    logic       txw [4];
    logic       rdy [4];
    logic       bsy [4];
    logic       dn  [4];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .s_data(sd[0][7:0]), .s_valid(sv[0]),
        .s_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]), .done(dn[0]));

    uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .reset(reset), .s_data(sd[1][6:0]), .s_valid(sv[1]),
        .s_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]), .done(dn[1]));

    uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
        .clk(clk), .reset(reset), .s_data(sd[2][6:0]), .s_valid(sv[2]),
        .s_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]), .done(dn[2]));

    uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .s_data(sd[3][7:0]), .s_valid(sv[3]),
        .s_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]), .done(dn[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the acceptance edge (10 clocks per bit).
    function automatic logic exp_tx(input logic [8:0] d, input int nb, input int par, input int k);
        int   idx;
        logic p;
        idx = k / 10;
        p   = 1'b0;
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        if (idx == 0) return 1'b0;
        if (idx <= nb) return d[idx-1];
        if (par != 0 && idx == nb + 1) return (par == 1) ? ~p : p;
        return 1'b1;
    endfunction

    // Entered at the negedge of cycle 0 (just after acceptance); leaves at cycle L.
    task automatic check_frame(input int u, input logic [8:0] d, input int nb, input int par,
                               input int ns, input bit b2b, input int pulse_at, input int hold_at,
                               input logic [8:0] alt, input string tag);
        int len;
        len = (1 + nb + ((par != 0) ? 1 : 0) + ns) * 10;
        for (int k = 0; k < len; k++) begin
            chk($sformatf("%s tx k=%0d", tag, k), txw[u], exp_tx(d, nb, par, k));
            chk($sformatf("%s s_ready k=%0d", tag, k), rdy[u], (k == len - 1));
            chk($sformatf("%s busy k=%0d", tag, k), bsy[u], 1);
            if (k > 0) chk($sformatf("%s done k=%0d", tag, k), dn[u], 0);
            if (k == pulse_at) begin
                sd[u] = alt;
                sv[u] = 1'b1;
            end else if (pulse_at >= 0 && k == pulse_at + 1) begin
                sv[u] = 1'b0;
            end
            if (k == hold_at) begin
                sd[u] = alt;
                sv[u] = 1'b1;
            end
            @(negedge clk);
        end
        chk($sformatf("%s done at end", tag), dn[u], 1);
        chk($sformatf("%s tx at end", tag), txw[u], b2b ? 0 : 1);
        chk($sformatf("%s busy at end", tag), bsy[u], b2b ? 1 : 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 4; u++) begin
            sd[u] = '0;
            sv[u] = 1'b0;
        end
        repeat (3) @(negedge clk);

        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset tx u%0d", u), txw[u], 1);
            chk($sformatf("reset busy u%0d", u), bsy[u], 0);
            chk($sformatf("reset done u%0d", u), dn[u], 0);
            chk($sformatf("reset s_ready u%0d", u), rdy[u], 1);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset s_ready", rdy[0], 1);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        sd[0] = 9'h0A5; sv[0] = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0;
        check_frame(0, 9'h0A5, 8, 0, 1, 1'b0, -1, -1, 9'h000, "t1_8n1_a5");
        @(negedge clk);
        chk("t1 done single cycle", dn[0], 0);

        // 7E1 and 7O1 with 0x53 (four ones): parity 0 and 1
        sd[1] = 9'h053; sv[1] = 1'b1;
        @(negedge clk);
        sv[1] = 1'b0;
        check_frame(1, 9'h053, 7, 2, 1, 1'b0, -1, -1, 9'h000, "t2_7e1_53");
        sd[2] = 9'h053; sv[2] = 1'b1;
        @(negedge clk);
        sv[2] = 1'b0;
        check_frame(2, 9'h053, 7, 1, 1, 1'b0, -1, -1, 9'h000, "t2_7o1_53");

        // 8N2 0x00: 90 low then 20 high, done at 110
        sd[3] = 9'h000; sv[3] = 1'b1;
        @(negedge clk);
        sv[3] = 1'b0;
        check_frame(3, 9'h000, 8, 0, 2, 1'b0, -1, -1, 9'h000, "t3_8n2_00");

        // back-to-back 0x0F then 0xF0 with s_valid held
        sd[0] = 9'h00F; sv[0] = 1'b1;
        @(negedge clk);
        sd[0] = 9'h0F0;
        check_frame(0, 9'h00F, 8, 0, 1, 1'b1, -1, -1, 9'h000, "t4_b2b_0f");
        sv[0] = 1'b0;
        check_frame(0, 9'h0F0, 8, 0, 1, 1'b0, -1, -1, 9'h000, "t4_b2b_f0");

        // reset during data bit 3 of 0xFF
        sd[0] = 9'h0FF; sv[0] = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0;
        repeat (43) @(negedge clk);
        chk("t5 tx during bit3", txw[0], 1);
        chk("t5 busy during bit3", bsy[0], 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5 tx after reset", txw[0], 1);
        chk("t5 busy after reset", bsy[0], 0);
        chk("t5 s_ready after reset", rdy[0], 1);
        chk("t5 done after reset", dn[0], 0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("t5 idle done k=%0d", k), dn[0], 0);
            chk($sformatf("t5 idle tx k=%0d", k), txw[0], 1);
        end
        sd[0] = 9'h03C; sv[0] = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0;
        check_frame(0, 9'h03C, 8, 0, 1, 1'b0, -1, -1, 9'h000, "t5_after_3c");

        // mid-frame s_data/s_valid activity while sending 0xAA
        sd[0] = 9'h0AA; sv[0] = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0;
        check_frame(0, 9'h0AA, 8, 0, 1, 1'b1, 30, 50, 9'h055, "t6_aa");
        sv[0] = 1'b0;
        check_frame(0, 9'h055, 8, 0, 1, 1'b0, -1, -1, 9'h000, "t6_55");
        @(negedge clk);
        chk("t6 idle after", bsy[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
